// File: rtl/sweep_counter_ctrl.sv
// sweep_counter_ctrl: command-driven sequencer for an 8-bit loadable up/down counter.
// Produces ramp (start->end) or triangle (start->end->start) sweeps. Each value is held
// for dwell+1 cycles, and the sweep repeats reps+1 times. The controller tracks the value
// the counter should hold (exp_q) so that it can decide when a leg is finished.
//
// Optional build macro: SWEEP_CHECK_EN. When it is defined, ctr_value is compared against
// the tracked value in every RUN cycle, and a mismatch sets the sticky err flag. The flag
// clears on the next command accept. When the macro is undefined, err is tied low.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_start/cmd_end    sweep start and turn/final value
//   cmd_mode             0 = ramp, 1 = triangle
//   cmd_reps             repetitions minus one
//   cmd_dwell            extra hold cycles per value
//   abort                synchronous abort of a running sweep
//   ctr_load/ctr_parallel/ctr_dir/ctr_pause  counter controls
//   ctr_value            counter readback (checker only)
//   busy, done, aborted  status; done and aborted are one-cycle pulses
//   err                  sticky readback mismatch
module sweep_counter_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_start,
  input  logic [W-1:0]  cmd_end,
  input  logic          cmd_mode,
  input  logic [DW-1:0] cmd_reps,
  input  logic [DW-1:0] cmd_dwell,
  input  logic          abort,
  output logic          ctr_load,
  output logic [W-1:0]  ctr_parallel,
  output logic          ctr_dir,
  output logic          ctr_pause,
  input  logic [W-1:0]  ctr_value,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          err
);

  localparam logic [W-1:0]  OneW  = W'(1);
  localparam logic [DW-1:0] OneDw = DW'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  start_q, start_d, end_q, end_d, exp_q, exp_d;
  logic          mode_q, mode_d, up_q, up_d, leg_q, leg_d, aborted_q, aborted_d;
  logic [DW-1:0] reps_q, reps_d, dwell_q, dwell_d, dcnt_q, dcnt_d;

  logic          accept, dwell_done, turn, eff_leg, eff_up, at_target, step;
  logic [W-1:0]  target;

  assign accept     = (state_q == StIdle) && cmd_valid;
  assign dwell_done = (dcnt_q >= dwell_q);
  // At the turn value of a triangle, leg 1 is evaluated in the same cycle, so the turn
  // value is held only once and the down step happens straight away.
  assign turn       = mode_q && !leg_q && (exp_q == end_q);
  assign eff_leg    = leg_q || turn;
  assign target     = eff_leg ? start_q : end_q;
  assign eff_up     = eff_leg ? !up_q : up_q;
  assign at_target  = (exp_q == target);
  assign step       = (state_q == StRun) && dwell_done && !at_target;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    mode_d    = mode_q;
    up_d      = up_q;
    reps_d    = reps_q;
    dwell_d   = dwell_q;
    exp_d     = exp_q;
    dcnt_d    = dcnt_q;
    leg_d     = leg_q;
    aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          start_d = cmd_start;
          end_d   = cmd_end;
          mode_d  = cmd_mode;
          reps_d  = cmd_reps;
          dwell_d = cmd_dwell;
          up_d    = (cmd_end >= cmd_start);
        end
      end
      StLoad: begin
        exp_d   = start_q;
        dcnt_d  = '0;
        leg_d   = 1'b0;
        state_d = StRun;
      end
      StRun: begin
        if (!dwell_done) begin
          dcnt_d = dcnt_q + OneDw;
        end else if (!at_target) begin
          exp_d  = eff_up ? exp_q + OneW : exp_q - OneW;
          dcnt_d = '0;
          leg_d  = eff_leg;
        end else if (reps_q != '0) begin
          reps_d  = reps_q - OneDw;
          state_d = StLoad;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      start_q   <= '0;
      end_q     <= '0;
      mode_q    <= 1'b0;
      up_q      <= 1'b0;
      reps_q    <= '0;
      dwell_q   <= '0;
      exp_q     <= '0;
      dcnt_q    <= '0;
      leg_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      end_q     <= end_d;
      mode_q    <= mode_d;
      up_q      <= up_d;
      reps_q    <= reps_d;
      dwell_q   <= dwell_d;
      exp_q     <= exp_d;
      dcnt_q    <= dcnt_d;
      leg_q     <= leg_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef SWEEP_CHECK_EN
  logic err_q, err_d;

  // The counter reflects exp_q in every RUN cycle (loaded or stepped on the previous edge).
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == StRun) && (ctr_value != exp_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_ctr_value;
  assign unused_ctr_value = ^ctr_value;
  assign err = 1'b0;
`endif

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign ctr_load     = (state_q == StLoad);
  assign ctr_parallel = start_q;
  assign ctr_dir      = (state_q == StRun) ? eff_up : 1'b1;
  assign ctr_pause    = !step;
  assign done         = (state_q == StDone);
  assign aborted      = aborted_q;

endmodule
